instr_fetch_queue: RTL and testbench

//  Sits between the AXI read-data channel (R) and instruction decode. Accepts 64-bit burst beats, splits each into
//  two 32-bit RV64 instructions, and tags each instruction with its PC. Buffers them in a DEPTH-entry FIFO.

---
 rtl/instr_fetch_queue.sv | 148 ++++++++++++++
 tb/tb_instr_fetch_queue.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: splits 64-bit AXI R beats into PC-tagged 32-bit instructions for decode.
// Optional trace output is enabled by defining FETCHQ_TRACE_EN.
module instr_fetch_queue #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush_i,
    input  logic [ADDR_WIDTH-1:0]   flush_pc_i,
    input  logic                    beat_valid_i,
    output logic                    beat_ready_o,
    input  logic [DATA_WIDTH-1:0]   beat_data_i,
    input  logic                    beat_last_i,
    input  logic [1:0]              beat_resp_i,
    output logic                    instr_valid_o,
    input  logic                    instr_ready_i,
    output logic [31:0]             instr_o,
    output logic [ADDR_WIDTH-1:0]   instr_pc_o,
    output logic                    instr_err_o,
    output logic                    halt_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {STREAM, DRAIN} state_t;

    typedef struct packed {
        logic [31:0]           word;
        logic [ADDR_WIDTH-1:0] pc;
        logic                  err;
    } entry_t;

    entry_t                mem [DEPTH];
    state_t                state;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count, count_next, room;
    logic [ADDR_WIDTH-1:0] pc, pc_next;
    logic                  halt_seen, burst_open, halt_q;
    logic                  beat_fire, pop, term, beat_err;
    logic [1:0]            push_n;
    logic [31:0]           lo, hi;
    entry_t                w0, w1;

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign room          = CW'(DEPTH) - count;
    assign beat_ready_o  = reset && !flush_i &&
                           ((state == DRAIN) || ((room >= CW'(2)) && !halt_seen));
    assign beat_fire     = beat_valid_i && beat_ready_o;
    assign instr_valid_o = (count != '0);
    assign pop           = instr_valid_o && instr_ready_i;
    assign lo            = beat_data_i[31:0];
    assign hi            = beat_data_i[DATA_WIDTH-1:32];
    assign beat_err      = |beat_resp_i;

    assign instr_o     = mem[rd_ptr].word;
    assign instr_pc_o  = mem[rd_ptr].pc;
    assign instr_err_o = mem[rd_ptr].err;
    assign halt_o      = halt_q;
    assign count_o     = count;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w0      = '0;
        w1      = '0;
        push_n  = 2'd0;
        term    = 1'b0;
        pc_next = pc;
        if (beat_fire && state == STREAM) begin
            if (!pc[2]) begin
                pc_next = pc + ADDR_WIDTH'(8);
                if (lo == 32'h0) begin
                    term = 1'b1;
                end else begin
                    w0     = '{word: lo, pc: pc, err: beat_err};
                    push_n = 2'd1;
                    if (hi == 32'h0) begin
                        term = 1'b1;
                    end else begin
                        w1     = '{word: hi, pc: pc + ADDR_WIDTH'(4), err: beat_err};
                        push_n = 2'd2;
                    end
                end
            end else begin
                pc_next = pc + ADDR_WIDTH'(4);
                if (hi == 32'h0) begin
                    term = 1'b1;
                end else begin
                    w0     = '{word: hi, pc: pc, err: beat_err};
                    push_n = 2'd1;
                end
            end
        end
        count_next = count + CW'(push_n) - CW'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= STREAM;
            pc         <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            halt_seen  <= 1'b0;
            burst_open <= 1'b0;
            halt_q     <= 1'b0;
            // NOTE: the array is reset because the head is driven straight from it and must read 0 in reset.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush_i) begin
            pc        <= flush_pc_i;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            halt_seen <= 1'b0;
            halt_q    <= 1'b0;
            state     <= (burst_open || (beat_valid_i && !beat_last_i)) ? DRAIN : STREAM;
        end else begin
            if (push_n != 2'd0) mem[wr_ptr] <= w0;
            if (push_n == 2'd2) mem[wr_ptr + PW'(1)] <= w1;
            wr_ptr    <= wr_ptr + PW'(push_n);
            rd_ptr    <= rd_ptr + PW'(pop);
            count     <= count_next;
            pc        <= pc_next;
            halt_seen <= halt_seen || term;
            halt_q    <= (halt_seen || term) && (count_next == '0);
            if (beat_fire) begin
                burst_open <= !beat_last_i;
                if (state == DRAIN && beat_last_i) state <= STREAM;
            end
        end
    end

`ifdef FETCHQ_TRACE_EN
    logic halt_d;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halt_d <= 1'b0;
        end else begin
            halt_d <= halt_q;
            if (pop && !flush_i) $display("%x :%h", instr_pc_o, instr_o);
            if (halt_q && !halt_d) $display("fetch halt at %x", pc);
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed vector table, corner sequences and random traffic vs a queue model.
module tb_instr_fetch_queue;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush_i = 1'b0;
    logic [63:0]   flush_pc_i = '0;
    logic          beat_valid_i = 1'b0;
    logic          beat_ready_o;
    logic [63:0]   beat_data_i = '0;
    logic          beat_last_i = 1'b0;
    logic [1:0]    beat_resp_i = '0;
    logic          instr_valid_o;
    logic          instr_ready_i = 1'b0;
    logic [31:0]   instr_o;
    logic [63:0]   instr_pc_o;
    logic          instr_err_o;
    logic          halt_o;
    logic [CW-1:0] count_o;

    instr_fetch_queue #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .beat_valid_i(beat_valid_i), .beat_ready_o(beat_ready_o), .beat_data_i(beat_data_i),
        .beat_last_i(beat_last_i), .beat_resp_i(beat_resp_i), .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_err_o(instr_err_o), .halt_o(halt_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic [63:0] fpc, input logic bv, input logic [63:0] data,
                         input logic last, input logic [1:0] resp, input logic rdy);
        flush_i = fl; flush_pc_i = fpc; beat_valid_i = bv; beat_data_i = data;
        beat_last_i = last; beat_resp_i = resp; instr_ready_i = rdy;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ready"}, beat_ready_o, 0);
        check({tag, " valid"}, instr_valid_o, 0);
        check({tag, " instr"}, instr_o, 0);
        check({tag, " pc"}, instr_pc_o, 0);
        check({tag, " err"}, instr_err_o, 0);
        check({tag, " halt"}, halt_o, 0);
        check({tag, " count"}, count_o, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic fl; logic [63:0] fpc; logic bv; logic [63:0] data; logic last; logic [1:0] resp; logic rdy;
        logic e_ready; logic e_valid; logic [31:0] e_instr; logic [63:0] e_pc; logic e_err;
        logic [3:0] e_count; logic e_halt;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic fl, input logic [63:0] fpc, input logic bv, input logic [63:0] data,
                                input logic last, input logic [1:0] resp, input logic rdy,
                                input logic e_ready, input logic e_valid, input logic [31:0] e_instr,
                                input logic [63:0] e_pc, input logic e_err, input logic [3:0] e_count,
                                input logic e_halt);
        vec_t v;
        v.fl = fl; v.fpc = fpc; v.bv = bv; v.data = data; v.last = last; v.resp = resp; v.rdy = rdy;
        v.e_ready = e_ready; v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc = e_pc; v.e_err = e_err;
        v.e_count = e_count; v.e_halt = e_halt;
        return v;
    endfunction

    // ---------------- behavioural reference model ----------------
    typedef struct { logic [31:0] word; logic [63:0] pc; logic err; } ent_t;

    ent_t        mq[$];
    logic [63:0] m_pc;
    logic        m_halt_seen, m_drain, m_open, m_halt_o;

    task automatic model_reset();
        mq.delete();
        m_pc = '0; m_halt_seen = 1'b0; m_drain = 1'b0; m_open = 1'b0; m_halt_o = 1'b0;
    endtask

    // One clock edge of the model: beat words occupy the two aligned 4-byte slots of an 8-byte line;
    // only slots at or above the current PC are taken, in address order, stopping at a zero word.
    task automatic model_update(input logic fl, input logic [63:0] fpc, input logic bv, input logic acc,
                                input logic [63:0] data, input logic last, input logic [1:0] resp,
                                input logic rdy);
        logic [63:0] base, addr;
        logic [31:0] w;
        logic        stop;
        if (fl) begin
            mq.delete();
            m_halt_seen = 1'b0;
            m_halt_o    = 1'b0;
            m_pc        = fpc;
            m_drain     = m_open || (bv && !last);
        end else begin
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (acc) begin
                if (!m_drain) begin
                    base = {m_pc[63:3], 3'b000};
                    stop = 1'b0;
                    for (int k = 0; k < 2; k++) begin
                        addr = base + 64'(4 * k);
                        w    = data[32*k +: 32];
                        if (addr >= m_pc && !stop) begin
                            if (w == 32'h0) begin
                                m_halt_seen = 1'b1;
                                stop = 1'b1;
                            end else begin
                                mq.push_back('{word: w, pc: addr, err: (resp != 2'b00)});
                            end
                        end
                    end
                    m_pc = base + 64'd8;
                end else if (last) begin
                    m_drain = 1'b0;
                end
                m_open = !last;
            end
            m_halt_o = m_halt_seen && (mq.size() == 0);
        end
    endtask

    task automatic step(input logic fl, input logic [63:0] fpc, input logic bv, input logic [63:0] data,
                        input logic last, input logic [1:0] resp, input logic rdy, input string tag,
                        output logic acc);
        logic e_ready;
        drive(fl, fpc, bv, data, last, resp, rdy);
        #1;
        e_ready = !fl && (m_drain || ((DEPTH - mq.size()) >= 2 && !m_halt_seen));
        check({tag, " ready"}, beat_ready_o, e_ready);
        check({tag, " valid"}, instr_valid_o, mq.size() != 0);
        check({tag, " count"}, count_o, mq.size());
        check({tag, " halt"}, halt_o, m_halt_o);
        if (mq.size() != 0) begin
            check({tag, " instr"}, instr_o, mq[0].word);
            check({tag, " pc"}, instr_pc_o, mq[0].pc);
            check({tag, " err"}, instr_err_o, mq[0].err);
        end
        acc = bv && e_ready;
        @(posedge clk);
        model_update(fl, fpc, bv, acc, data, last, resp, rdy);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rword();
        return ($urandom_range(0, 24) == 0) ? 32'h0 : ($urandom | 32'h1);
    endfunction

    function automatic logic [63:0] fill_beat(input int i);
        return {16'hC0DE, 16'(2 * i + 1), 16'hC0DE, 16'(2 * i)};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        logic acc;
        int   bi;

        // Reset state, with a pending beat to prove ready is held low.
        beat_valid_i = 1'b1;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        vt.push_back(mk(1, 64'h1000, 0, 64'h0, 0, 2'b00, 0,   0, 0, 32'h0, 64'h0, 0, 0, 0));
        vt.push_back(mk(0, 64'h0, 1, 64'h00A00513_00100093, 1, 2'b00, 0,   1, 0, 32'h0, 64'h0, 0, 0, 0));
        vt.push_back(mk(0, 64'h0, 0, 64'h0, 0, 2'b00, 0,   1, 1, 32'h00100093, 64'h1000, 0, 2, 0));
        vt.push_back(mk(0, 64'h0, 0, 64'h0, 0, 2'b00, 1,   1, 1, 32'h00100093, 64'h1000, 0, 2, 0));
        vt.push_back(mk(0, 64'h0, 0, 64'h0, 0, 2'b00, 1,   1, 1, 32'h00A00513, 64'h1004, 0, 1, 0));
        vt.push_back(mk(0, 64'h0, 0, 64'h0, 0, 2'b00, 0,   1, 0, 32'h0, 64'h0, 0, 0, 0));
        vt.push_back(mk(1, 64'h1004, 0, 64'h0, 0, 2'b00, 0,   0, 0, 32'h0, 64'h0, 0, 0, 0));
        vt.push_back(mk(0, 64'h0, 1, 64'h22222222_11111111, 0, 2'b00, 0,   1, 0, 32'h0, 64'h0, 0, 0, 0));
        vt.push_back(mk(0, 64'h0, 1, 64'h44444444_33333333, 1, 2'b00, 0,   1, 1, 32'h22222222, 64'h1004, 0, 1, 0));
        vt.push_back(mk(0, 64'h0, 0, 64'h0, 0, 2'b00, 1,   1, 1, 32'h22222222, 64'h1004, 0, 3, 0));
        vt.push_back(mk(0, 64'h0, 0, 64'h0, 0, 2'b00, 1,   1, 1, 32'h33333333, 64'h1008, 0, 2, 0));
        vt.push_back(mk(0, 64'h0, 0, 64'h0, 0, 2'b00, 1,   1, 1, 32'h44444444, 64'h100C, 0, 1, 0));
        vt.push_back(mk(0, 64'h0, 0, 64'h0, 0, 2'b00, 0,   1, 0, 32'h0, 64'h0, 0, 0, 0));
        vt.push_back(mk(0, 64'h0, 1, 64'h00000000_00000013, 1, 2'b10, 0,   1, 0, 32'h0, 64'h0, 0, 0, 0));
        vt.push_back(mk(0, 64'h0, 1, 64'h55555555_66666666, 1, 2'b00, 1,   0, 1, 32'h13, 64'h1010, 1, 1, 0));
        vt.push_back(mk(0, 64'h0, 1, 64'h55555555_66666666, 1, 2'b00, 0,   0, 0, 32'h0, 64'h0, 0, 0, 1));
        vt.push_back(mk(0, 64'h0, 1, 64'h55555555_66666666, 1, 2'b00, 0,   0, 0, 32'h0, 64'h0, 0, 0, 1));
        vt.push_back(mk(1, 64'h2000, 0, 64'h0, 0, 2'b00, 0,   0, 0, 32'h0, 64'h0, 0, 0, 1));
        vt.push_back(mk(0, 64'h0, 0, 64'h0, 0, 2'b00, 0,   1, 0, 32'h0, 64'h0, 0, 0, 0));
        vt.push_back(mk(0, 64'h0, 1, 64'hBBBBBBBB_AAAAAAAA, 1, 2'b10, 0,   1, 0, 32'h0, 64'h0, 0, 0, 0));
        vt.push_back(mk(0, 64'h0, 0, 64'h0, 0, 2'b00, 1,   1, 1, 32'hAAAAAAAA, 64'h2000, 1, 2, 0));
        vt.push_back(mk(0, 64'h0, 0, 64'h0, 0, 2'b00, 1,   1, 1, 32'hBBBBBBBB, 64'h2004, 1, 1, 0));
        vt.push_back(mk(0, 64'h0, 0, 64'h0, 0, 2'b00, 0,   1, 0, 32'h0, 64'h0, 0, 0, 0));

        foreach (vt[i]) begin
            drive(vt[i].fl, vt[i].fpc, vt[i].bv, vt[i].data, vt[i].last, vt[i].resp, vt[i].rdy);
            #1;
            check($sformatf("vec%0d ready", i), beat_ready_o, vt[i].e_ready);
            check($sformatf("vec%0d valid", i), instr_valid_o, vt[i].e_valid);
            check($sformatf("vec%0d count", i), count_o, vt[i].e_count);
            check($sformatf("vec%0d halt", i), halt_o, vt[i].e_halt);
            if (vt[i].e_valid) begin
                check($sformatf("vec%0d instr", i), instr_o, vt[i].e_instr);
                check($sformatf("vec%0d pc", i), instr_pc_o, vt[i].e_pc);
                check($sformatf("vec%0d err", i), instr_err_o, vt[i].e_err);
            end
            @(posedge clk);
            @(negedge clk);
        end

        // Fresh start for the model-checked sequences.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        model_reset();
        @(negedge clk);

        // Backpressure: 8-beat burst into an 8-entry queue with decode stalled.
        step(1, 64'h3000, 0, 64'h0, 0, 2'b00, 0, "full flush", acc);
        bi = 0;
        for (int c = 0; c < 6; c++) begin
            step(0, 64'h0, 1, fill_beat(bi), bi == 7, 2'b00, 0, "full fill", acc);
            if (acc) bi++;
        end
        check("full count", count_o, 8);
        check("full ready", beat_ready_o, 0);
        for (int c = 0; c < 2; c++) begin
            step(0, 64'h0, 1, fill_beat(bi), bi == 7, 2'b00, 1, "full pop", acc);
            if (acc) bi++;
        end
        check("full ready back", beat_ready_o, 1);
        for (int c = 0; c < 40 && (bi < 8 || mq.size() != 0); c++) begin
            step(0, 64'h0, bi < 8, fill_beat(bi), bi == 7, 2'b00, 1, "full drain", acc);
            if (acc) bi++;
        end
        check("full all consumed", count_o, 0);

        // Flush after beat 2 of 8: remaining beats discarded, next burst lands at the flush PC.
        step(1, 64'h4000, 0, 64'h0, 0, 2'b00, 0, "drain flush0", acc);
        for (int i = 0; i < 2; i++) step(0, 64'h0, 1, fill_beat(i), 0, 2'b00, 1, "drain pre", acc);
        step(1, 64'h5000, 1, fill_beat(2), 0, 2'b00, 1, "drain flush", acc);
        for (int i = 2; i < 8; i++) begin
            step(0, 64'h0, 1, fill_beat(i), i == 7, 2'b00, 1, "drain skip", acc);
            check($sformatf("drain skip%0d count", i), count_o, 0);
        end
        step(0, 64'h0, 1, 64'h77777777_66666666, 1, 2'b00, 0, "drain new", acc);
        check("drain new pc", instr_pc_o, 64'h5000);
        check("drain new instr", instr_o, 32'h66666666);
        for (int c = 0; c < 3; c++) step(0, 64'h0, 0, 64'h0, 0, 2'b00, 1, "drain empty", acc);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            logic        fl;
            logic [63:0] fpc;
            logic [1:0]  rsp;
            fl  = ($urandom_range(0, 39) == 0);
            fpc = 64'h8000 + 64'(4 * $urandom_range(0, 1023));
            rsp = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(fl, fpc, $urandom_range(0, 2) != 0, {rword(), rword()}, $urandom_range(0, 3) == 0,
                 rsp, $urandom_range(0, 3) != 0, "rnd", acc);
        end

        // Asynchronous reset in the middle of a burst with a partly full queue.
        step(1, 64'h9000, 0, 64'h0, 0, 2'b00, 0, "areset flush", acc);
        step(0, 64'h0, 1, 64'h12345678_9ABCDEF0, 0, 2'b00, 0, "areset beat0", acc);
        step(0, 64'h0, 1, 64'h0FEDCBA9_87654321, 0, 2'b00, 0, "areset beat1", acc);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("areset");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        step(1, 64'hA000, 0, 64'h0, 0, 2'b00, 0, "post flush", acc);
        step(0, 64'h0, 1, 64'hDDDDDDDD_CCCCCCCC, 1, 2'b00, 0, "post beat", acc);
        for (int c = 0; c < 3; c++) step(0, 64'h0, 0, 64'h0, 0, 2'b00, 1, "post pop", acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
